// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: responder states, phase lengths in microseconds,
// frame width and the payload checksum used by both ends of the link.
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE, HOST_LOW, GAP, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  localparam int unsigned GAP_US       = 30;
  localparam int unsigned ACK_LOW_US   = 80;
  localparam int unsigned ACK_HIGH_US  = 80;
  localparam int unsigned BIT_LOW_US   = 50;
  localparam int unsigned BIT0_HIGH_US = 26;
  localparam int unsigned BIT1_HIGH_US = 70;
  localparam int unsigned END_LOW_US   = 50;
  localparam int unsigned FRAME_BITS   = 40;

  function automatic logic [7:0] dht11_cksum(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
    return b0 + b1 + b2 + b3;
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Microsecond prescaler: one-cycle tick every CYC_PER_US clocks, restartable
// so that every FSM phase starts counting from a fresh microsecond.
module dht11_us_tick #(
  parameter int CYC_PER_US = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int CW = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(CYC_PER_US - 1));
  // A stale wrap from the previous phase must not leak into the new one.
  assign tick = wrap && !restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (restart || wrap)  cnt <= '0;
    else                       cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 device-side responder: detects a host start pulse, answers with ACK and
// a 40-bit frame, open-drain. Optional DHT11_RESP_CKSUM_FAULT_EN adds cksum_fault.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int CYC_PER_US   = 100,
  parameter int START_MIN_US = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dht_in,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
`ifdef DHT11_RESP_CKSUM_FAULT_EN
  input  logic       cksum_fault,
`endif
  output logic       dht_oe,
  output logic       busy,
  output logic       frame_done,
  output logic       bus_err
);

  logic                  sync1, s;
  state_t                state, nxt;
  logic                  restart, tick, low_seen, abort, phase_end, shift;
  logic [15:0]           us_cnt, phase_len;
  logic [5:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [7:0]            cks;

  // Line idles high via the pull-up, so the synchronizer resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {sync1, s} <= 2'b11;
    else        {sync1, s} <= {dht_in, sync1};
  end

  dht11_us_tick #(.CYC_PER_US(CYC_PER_US)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

`ifdef DHT11_RESP_CKSUM_FAULT_EN
  assign cks = dht11_cksum(hum_int, hum_dec, temp_int, temp_dec) ^ {7'd0, cksum_fault};
`else
  assign cks = dht11_cksum(hum_int, hum_dec, temp_int, temp_dec);
`endif

  always_comb begin
    phase_len = '0;
    case (state)
      GAP:      phase_len = 16'(GAP_US);
      ACK_LOW:  phase_len = 16'(ACK_LOW_US);
      ACK_HIGH: phase_len = 16'(ACK_HIGH_US);
      BIT_LOW:  phase_len = 16'(BIT_LOW_US);
      BIT_HIGH: phase_len = shreg[FRAME_BITS-1] ? 16'(BIT1_HIGH_US) : 16'(BIT0_HIGH_US);
      END_LOW:  phase_len = 16'(END_LOW_US);
      default:  phase_len = '0;
    endcase
  end

  assign phase_end = tick && (us_cnt == phase_len - 16'd1);
  // Contention is only visible while we release the line.
  assign abort = tick && !s && low_seen &&
                 (state == GAP || state == ACK_HIGH || state == BIT_HIGH);
  assign shift = (state == BIT_HIGH) && phase_end && !abort;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (!s) nxt = HOST_LOW;
      HOST_LOW: if (s) nxt = (us_cnt >= 16'(START_MIN_US)) ? GAP : IDLE;
      GAP:      if (abort) nxt = HOST_LOW; else if (phase_end) nxt = ACK_LOW;
      ACK_LOW:  if (phase_end) nxt = ACK_HIGH;
      ACK_HIGH: if (abort) nxt = HOST_LOW; else if (phase_end) nxt = BIT_LOW;
      BIT_LOW:  if (phase_end) nxt = BIT_HIGH;
      BIT_HIGH: if (abort) nxt = HOST_LOW;
                else if (phase_end) nxt = (bit_cnt == 6'(FRAME_BITS - 1)) ? END_LOW : BIT_LOW;
      END_LOW:  if (phase_end) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      restart    <= 1'b0;
      us_cnt     <= '0;
      low_seen   <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      dht_oe     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= nxt;
      restart    <= (nxt != state);
      dht_oe     <= (nxt == ACK_LOW) || (nxt == BIT_LOW) || (nxt == END_LOW);
      frame_done <= (state == END_LOW) && (nxt == IDLE);
      bus_err    <= abort;

      if (nxt != state) begin
        us_cnt   <= '0;
        low_seen <= 1'b0;
      end else if (tick) begin
        if (us_cnt != '1) us_cnt <= us_cnt + 16'd1;
        low_seen <= !s;
      end

      if (state == HOST_LOW && nxt == GAP)
        busy <= 1'b1;
      else if (abort || (state == END_LOW && nxt == IDLE))
        busy <= 1'b0;

      if (state == GAP && nxt == ACK_LOW) begin
        shreg   <= {hum_int, hum_dec, temp_int, temp_dec, cks};
        bit_cnt <= '0;
      end else if (shift) begin
        shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Closed-loop bench for dht11_responder: plays the host on an open-drain line,
// measures every pulse width and decodes the frame against a payload model.
module tb_dht11_responder;
  localparam int C    = 2;   // cycles per microsecond in this bench
  localparam int SMIN = 20;  // scaled-down start threshold

  logic clk = 1'b0, rst_n = 1'b0, host_pull = 1'b0;
  logic [7:0] hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
  logic dht_in, dht_oe, busy, frame_done, bus_err;
`ifdef DHT11_RESP_CKSUM_FAULT_EN
  logic cksum_fault = 1'b0;
`endif

  assign dht_in = ~(dht_oe | host_pull);
  always #5 clk = ~clk;

  dht11_responder #(.CYC_PER_US(C), .START_MIN_US(SMIN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dht_in     (dht_in),
    .hum_int    (hum_int),
    .hum_dec    (hum_dec),
    .temp_int   (temp_int),
    .temp_dec   (temp_dec),
`ifdef DHT11_RESP_CKSUM_FAULT_EN
    .cksum_fault(cksum_fault),
`endif
    .dht_oe     (dht_oe),
    .busy       (busy),
    .frame_done (frame_done),
    .bus_err    (bus_err)
  );

  int total = 0, bad = 0;
  int lo_w[41];
  int hi_w[40];
  int gap_w, ack_lo_w, ack_hi_w, fd_cnt, be_cnt;
  logic [39:0] rx;
  bit tmo, fd_at_end, busy_at_end, busy_at_ack;

  // Expected frame straight from the protocol rules.
  function automatic logic [39:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d, input logic f);
    int sum;
    sum = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
    return {a, b, c, d, 8'(sum) ^ {7'd0, f}};
  endfunction

  function automatic bit near(input int w, input int us);
    return (w >= us * C - 1) && (w <= us * C + 1);
  endfunction

  task automatic tick_sample();
    @(negedge clk);
    if (frame_done) fd_cnt++;
    if (bus_err) be_cnt++;
  endtask

  task automatic wait_oe(input logic v, output int n);
    n = 0;
    while (dht_oe !== v && !tmo) begin
      tick_sample();
      n++;
      if (n > 400) tmo = 1;
    end
  endtask

  task automatic host_start(input int us);
    @(negedge clk) host_pull = 1'b1;
    repeat (us * C) @(negedge clk);
    host_pull = 1'b0;
  endtask

  task automatic set_payload(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
    hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
  endtask

  // Called right after the host release; abort_bit >= 0 jams that bit's high phase.
  task automatic capture_frame(input int abort_bit, input bit scramble);
    fd_cnt = 0; be_cnt = 0; tmo = 0; rx = '0;
    busy_at_ack = 0; fd_at_end = 0; busy_at_end = 1;
    wait_oe(1'b1, gap_w);
    busy_at_ack = busy;
    if (scramble) set_payload(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    wait_oe(1'b0, ack_lo_w);
    wait_oe(1'b1, ack_hi_w);
    for (int i = 0; i < 40 && !tmo; i++) begin
      wait_oe(1'b0, lo_w[i]);
      if (i == abort_bit) begin
        repeat (4) tick_sample();
        host_pull = 1'b1;
        repeat (5 * C) tick_sample();
        host_pull = 1'b0;
        return;
      end
      wait_oe(1'b1, hi_w[i]);
      rx[39-i] = (hi_w[i] > 48 * C);
    end
    wait_oe(1'b0, lo_w[40]);
    fd_at_end = frame_done;
    busy_at_end = busy;
    repeat (20) tick_sample();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({dht_oe, busy, frame_done, bus_err} !== 4'b0) begin
      bad++; $display("FAIL reset_hold: got %b want 0000", {dht_oe, busy, frame_done, bus_err});
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if ({dht_oe, busy, frame_done, bus_err} !== 4'b0) begin
      bad++; $display("FAIL reset_idle: got %b want 0000", {dht_oe, busy, frame_done, bus_err});
    end
  endtask

  task automatic test_basic();
    logic [39:0] exp;
    set_payload(8'h37, 8'h00, 8'h19, 8'h00);
    exp = model(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
    host_start(30);
    capture_frame(-1, 1'b0);
    total++;
    if (tmo) begin bad++; $display("FAIL basic_timeout: frame stalled"); end
    total++;
    if (gap_w < 30 * C || gap_w > 30 * C + C + 4) begin
      bad++; $display("FAIL basic_gap: got %0d cycles want ~%0d", gap_w, 30 * C + 2);
    end
    total++;
    if (!near(ack_lo_w, 80) || !near(ack_hi_w, 80)) begin
      bad++; $display("FAIL basic_ack: got lo=%0d hi=%0d want %0d each", ack_lo_w, ack_hi_w, 80 * C);
    end
    total++;
    if (rx !== exp) begin bad++; $display("FAIL basic_frame: got %h want %h", rx, exp); end
    total++;
    if (rx[7:0] !== 8'h50) begin bad++; $display("FAIL basic_cksum: got %h want 50", rx[7:0]); end
    total++;
    if (fd_cnt != 1 || !fd_at_end) begin
      bad++; $display("FAIL basic_done: pulses=%0d at_end=%0d want 1/1", fd_cnt, fd_at_end);
    end
    total++;
    if (!busy_at_ack || busy_at_end) begin
      bad++; $display("FAIL basic_busy: at_ack=%0d at_end=%0d want 1/0", busy_at_ack, busy_at_end);
    end
    total++;
    if (!near(lo_w[40], 50)) begin bad++; $display("FAIL basic_end: got %0d want %0d", lo_w[40], 50 * C); end
  endtask

  task automatic test_glitch();
    int lens[2] = '{5, 15};
    foreach (lens[k]) begin
      bit seen = 0;
      host_start(lens[k]);
      repeat (300) begin
        @(negedge clk);
        if (dht_oe === 1'b1 || busy === 1'b1) seen = 1;
      end
      total++;
      if (seen) begin bad++; $display("FAIL glitch_%0dus: got response want none", lens[k]); end
    end
  endtask

  task automatic test_all_ones();
    logic [39:0] exp;
    int nhi = 0, nlo = 0;
    set_payload(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    exp = model(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    host_start(30);
    capture_frame(-1, 1'b0);
    total++;
    if (rx !== exp || rx[7:0] !== 8'hFC) begin bad++; $display("FAIL ones_frame: got %h want %h", rx, exp); end
    for (int i = 0; i < 40; i++) if (!near(hi_w[i], exp[39-i] ? 70 : 26)) nhi++;
    for (int i = 0; i < 41; i++) if (!near(lo_w[i], 50)) nlo++;
    total++;
    if (nhi != 0) begin bad++; $display("FAIL ones_high: got %0d bad widths (bit0=%0d) want 0", nhi, hi_w[0]); end
    total++;
    if (nlo != 0 || tmo) begin bad++; $display("FAIL ones_low: got %0d bad widths want 0", nlo); end
  endtask

  task automatic test_random();
    logic [7:0] a, b, c, d;
    logic [39:0] exp;
    int nhi = 0;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
    set_payload(a, b, c, d);
    exp = model(a, b, c, d, 1'b0);
    host_start(30);
    capture_frame(-1, 1'b1);
    total++;
    if (rx !== exp) begin bad++; $display("FAIL random_frame: got %h want %h", rx, exp); end
    for (int i = 0; i < 40; i++) if (!near(hi_w[i], exp[39-i] ? 70 : 26)) nhi++;
    total++;
    if (nhi != 0 || tmo) begin bad++; $display("FAIL random_high: got %0d bad widths want 0", nhi); end
    total++;
    if (fd_cnt != 1) begin bad++; $display("FAIL random_done: got %0d pulses want 1", fd_cnt); end
  endtask

  task automatic test_abort();
    logic [39:0] exp;
    bit stray = 0;
    set_payload(8'h5A, 8'hC3, 8'h0F, 8'h81);
    exp = model(8'h5A, 8'hC3, 8'h0F, 8'h81, 1'b0);
    host_start(30);
    capture_frame(12, 1'b0);
    total++;
    if (be_cnt != 1) begin bad++; $display("FAIL abort_err: got %0d pulses want 1", be_cnt); end
    total++;
    if (dht_oe !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_state: got oe=%b busy=%b want 0/0", dht_oe, busy);
    end
    repeat (100) begin
      @(negedge clk);
      if (dht_oe === 1'b1 || busy === 1'b1) stray = 1;
    end
    total++;
    if (stray) begin bad++; $display("FAIL abort_quiet: got activity want none"); end
    host_start(30);
    capture_frame(-1, 1'b0);
    total++;
    if (rx !== exp || fd_cnt != 1) begin
      bad++; $display("FAIL abort_retry: got %h/%0d want %h/1", rx, fd_cnt, exp);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] a, b, c, d;
    logic [39:0] exp;
    tmo = 0;
    host_start(30);
    wait_oe(1'b1, gap_w);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (tmo || dht_oe !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid: got oe=%b busy=%b tmo=%0d want 0/0/0", dht_oe, busy, tmo);
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
    set_payload(a, b, c, d);
    exp = model(a, b, c, d, 1'b0);
    host_start(30);
    capture_frame(-1, 1'b0);
    total++;
    if (rx !== exp || fd_cnt != 1) begin
      bad++; $display("FAIL rst_retry: got %h/%0d want %h/1", rx, fd_cnt, exp);
    end
  endtask

`ifdef DHT11_RESP_CKSUM_FAULT_EN
  task automatic test_cksum_fault();
    set_payload(8'h37, 8'h00, 8'h19, 8'h00);
    cksum_fault = 1'b1;
    host_start(30);
    capture_frame(-1, 1'b0);
    cksum_fault = 1'b0;
    total++;
    if (rx[7:0] !== 8'h51) begin bad++; $display("FAIL cksum_fault: got %h want 51", rx[7:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_all_ones();
    test_random();
    test_abort();
    test_reset_midframe();
`ifdef DHT11_RESP_CKSUM_FAULT_EN
    test_cksum_fault();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
